// File: rtl/intpol2_pkg.sv
// Shared types and constants for the IntPol2 squared-term generator.
package intpol2_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic MODE_SQ  = 1'b0;
    localparam logic MODE_LIN = 1'b1;

    // Output width that holds |x2|*(D-1)^2 without overflow.
    function automatic int calc_out_w(input int data_width, input int n_bits, input int log2_d);
        return data_width + n_bits + 2 * log2_d;
    endfunction

endpackage

// File: rtl/intpol2_diff_acc.sv
// Difference-recurrence accumulator: acc steps by delta, delta steps by step2,
// producing x2*i^2 (step2 = 2*x2) or x2*i (step2 = 0) without a multiplier.
module intpol2_diff_acc
    import intpol2_pkg::*;
#(
    parameter int IN_W  = 34,
    parameter int OUT_W = 38
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    clear,
    input  logic                    load,
    input  logic                    advance,
    input  logic                    finish,
    input  logic                    mode,
    input  logic signed [IN_W-1:0]  x2,
    output logic signed [OUT_W-1:0] acc
);

    logic signed [OUT_W-1:0] x2_ext;
    logic signed [OUT_W-1:0] acc_q,   acc_d;
    logic signed [OUT_W-1:0] delta_q, delta_d;
    logic signed [OUT_W-1:0] step2_q, step2_d;

    assign x2_ext = {{(OUT_W-IN_W){x2[IN_W-1]}}, x2};

    // Next-state for the recurrence registers: load a new sample, advance one beat, or hold.
    always_comb begin
        acc_d   = acc_q;
        delta_d = delta_q;
        step2_d = step2_q;
        if (load) begin
            acc_d   = '0;
            delta_d = x2_ext;
            step2_d = (mode == MODE_LIN) ? '0 : (x2_ext <<< 1);
        end else if (advance) begin
            acc_d   = acc_q + delta_q;
            delta_d = delta_q + step2_q;
        end else if (finish) begin
            acc_d   = '0;
        end
    end

    // Register update; reset and clear zero everything and override any transfer.
    always_ff @(posedge clk) begin
        if (!rstn || clear) begin
            acc_q   <= '0;
            delta_q <= '0;
            step2_q <= '0;
        end else begin
            acc_q   <= acc_d;
            delta_q <= delta_d;
            step2_q <= step2_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/intpol2_squared_gen.sv
// Squared/linear term generator: accepts one x2 per interval and emits D beats
// of x2*i^2 (or x2*i) with valid/ready on both sides.
module intpol2_squared_gen
    import intpol2_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int N_bits     = 2,
    parameter int LOG2_D     = 2,
    parameter int OUT_W      = calc_out_w(DATA_WIDTH, N_bits, LOG2_D)
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               clear,
    input  logic                               mode,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic signed [DATA_WIDTH+N_bits-1:0] x2,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic signed [OUT_W-1:0]            xi2,
    output logic [LOG2_D-1:0]                  idx,
    output logic                               out_last
);

    localparam int W = DATA_WIDTH + N_bits;
    localparam logic [LOG2_D-1:0] CNT_LAST = '1;

    state_e            state_q, state_d;
    logic [LOG2_D-1:0] cnt_q, cnt_d;
    logic              load, advance, finish;
    logic signed [OUT_W-1:0] acc;

    // FSM next-state, beat counter and datapath controls.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        advance = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (out_ready) begin
                    if (cnt_q == CNT_LAST) begin
                        finish  = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        advance = 1'b1;
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and counter registers; reset or clear abandons any beat in flight.
    always_ff @(posedge clk) begin
        if (!rstn || clear) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    intpol2_diff_acc #(
        .IN_W  (W),
        .OUT_W (OUT_W)
    ) u_diff_acc (
        .clk     (clk),
        .rstn    (rstn),
        .clear   (clear),
        .load    (load),
        .advance (advance),
        .finish  (finish),
        .mode    (mode),
        .x2      (x2),
        .acc     (acc)
    );

    // Handshake outputs depend on registered state only.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == RUN);
    assign out_last  = (state_q == RUN) && (cnt_q == CNT_LAST);
    assign idx       = cnt_q;
    assign xi2       = acc;

endmodule

// File: tb/tb_intpol2_squared_gen.sv
// Bench for intpol2_squared_gen: D=4 and D=8 instances against a plain-arithmetic model.
module tb_intpol2_squared_gen;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic clear = 1'b0;
    int   cyc = 0;
    int   nvec = 0;
    int   nerr = 0;

    // D=4 instance
    logic               mode = 1'b0;
    logic               in_valid = 1'b0;
    logic               out_ready = 1'b0;
    logic signed [33:0] x2 = '0;
    logic               in_ready, out_valid, out_last;
    logic signed [37:0] xi2;
    logic [1:0]         idx;

    // D=8 instance
    logic               mode8 = 1'b0;
    logic               in_valid8 = 1'b0;
    logic               out_ready8 = 1'b0;
    logic signed [33:0] x2_8 = '0;
    logic               in_ready8, out_valid8, out_last8;
    logic signed [39:0] xi2_8;
    logic [2:0]         idx8;

    intpol2_squared_gen #(.DATA_WIDTH(32), .N_bits(2), .LOG2_D(2)) dut4 (
        .clk(clk), .rstn(rstn), .clear(clear), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .x2(x2),
        .out_valid(out_valid), .out_ready(out_ready), .xi2(xi2),
        .idx(idx), .out_last(out_last)
    );

    intpol2_squared_gen #(.DATA_WIDTH(32), .N_bits(2), .LOG2_D(3)) dut8 (
        .clk(clk), .rstn(rstn), .clear(clear), .mode(mode8),
        .in_valid(in_valid8), .in_ready(in_ready8), .x2(x2_8),
        .out_valid(out_valid8), .out_ready(out_ready8), .xi2(xi2_8),
        .idx(idx8), .out_last(out_last8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: the i-th term is x2*i*i (squared) or x2*i (linear).
    function automatic longint model(input longint v, input logic m, input int i);
        longint ii;
        ii = i;
        return m ? v * ii : v * ii * ii;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one sample to the D=4 instance and return the cycle it was accepted.
    task automatic send(input longint v, input logic m, output int acc_cyc);
        int guard;
        guard = 0;
        while (in_ready !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        nvec++;
        if (in_ready !== 1'b1) begin
            nerr++;
            $display("FAIL send_in_ready: got %b, want 1", in_ready);
        end
        x2 = v[33:0];
        mode = m;
        in_valid = 1'b1;
        tick();
        acc_cyc = cyc;
        in_valid = 1'b0;
        x2 = $urandom();
        mode = 1'($urandom_range(0, 1));
    endtask

    // Drain D=4 beats, stalling stall_n cycles at beat stall_at and optionally at random.
    task automatic beats4(input longint v, input logic m, input int stall_at, input int stall_n,
                          input bit rand_bp, input string tag);
        int  stalls;
        int  guard;
        bit  done;
        logic rdy;
        longint e;
        for (int i = 0; i < 4; i++) begin
            stalls = (i == stall_at) ? stall_n : 0;
            guard = 0;
            done = 1'b0;
            e = model(v, m, i);
            while (!done) begin
                if (stalls > 0) begin
                    rdy = 1'b0;
                    stalls--;
                end else if (rand_bp && guard < 20) begin
                    rdy = 1'($urandom_range(0, 1));
                end else begin
                    rdy = 1'b1;
                end
                out_ready = rdy;
                nvec++;
                if (out_valid !== 1'b1 || idx !== i[1:0] || longint'(xi2) !== e ||
                    out_last !== (i == 3) || in_ready !== 1'b0) begin
                    nerr++;
                    $display("FAIL %s beat%0d: got valid=%b idx=%0d xi2=%0d last=%b in_ready=%b, want valid=1 idx=%0d xi2=%0d last=%b in_ready=0",
                             tag, i, out_valid, idx, xi2, out_last, in_ready, i, e, (i == 3));
                end
                tick();
                guard++;
                done = rdy;
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) tick();
        nvec++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || xi2 !== '0 || idx !== '0 || in_ready !== 1'b1) begin
            nerr++;
            $display("FAIL reset: got valid=%b last=%b xi2=%0d idx=%0d in_ready=%b, want 0 0 0 0 1",
                     out_valid, out_last, xi2, idx, in_ready);
        end
        nvec++;
        if (out_valid8 !== 1'b0 || xi2_8 !== '0 || in_ready8 !== 1'b1) begin
            nerr++;
            $display("FAIL reset_d8: got valid=%b xi2=%0d in_ready=%b, want 0 0 1", out_valid8, xi2_8, in_ready8);
        end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_squared();
        int c;
        send(3, 1'b0, c);
        beats4(3, 1'b0, -1, 0, 1'b0, "squared");
        nvec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL squared_done: got in_ready=%b valid=%b, want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int c1, c2;
        send(3, 1'b1, c1);
        beats4(3, 1'b1, -1, 0, 1'b0, "linear");
        send(-5, 1'b0, c2);
        beats4(-5, 1'b0, -1, 0, 1'b0, "b2b_neg");
        nvec++;
        if (c2 - c1 !== 5) begin
            nerr++;
            $display("FAIL b2b_interval: got %0d cycles, want 5", c2 - c1);
        end
    endtask

    task automatic test_backpressure();
        int c;
        send(7, 1'b0, c);
        beats4(7, 1'b0, 2, 3, 1'b0, "backpressure");
    endtask

    task automatic test_extremes();
        int c;
        longint vmax, vmin;
        vmax = (longint'(1) <<< 33) - 1;
        vmin = -(longint'(1) <<< 33);
        send(vmax, 1'b0, c);
        beats4(vmax, 1'b0, -1, 0, 1'b0, "ext_max");
        send(vmin, 1'b0, c);
        beats4(vmin, 1'b0, -1, 0, 1'b0, "ext_min");
        send(vmin, 1'b1, c);
        beats4(vmin, 1'b1, -1, 0, 1'b0, "ext_min_lin");
    endtask

    task automatic test_midrun_abort();
        int c;
        for (int k = 0; k < 2; k++) begin
            send(5, 1'b0, c);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b1;
            if (k == 0) clear = 1'b1; else rstn = 1'b0;
            tick();
            clear = 1'b0;
            rstn = 1'b1;
            out_ready = 1'b0;
            nvec++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || xi2 !== '0 || idx !== '0 || out_last !== 1'b0) begin
                nerr++;
                $display("FAIL abort%0d: got valid=%b in_ready=%b xi2=%0d idx=%0d last=%b, want 0 1 0 0 0",
                         k, out_valid, in_ready, xi2, idx, out_last);
            end
            send(2, 1'b0, c);
            beats4(2, 1'b0, -1, 0, 1'b0, "after_abort");
        end
        // Clear coinciding with an input offer: nothing is accepted.
        clear = 1'b1;
        in_valid = 1'b1;
        x2 = 34'sd9;
        tick();
        clear = 1'b0;
        in_valid = 1'b0;
        nvec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            nerr++;
            $display("FAIL clear_vs_accept: got valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_random();
        int c;
        logic [63:0] raw;
        logic signed [33:0] r;
        logic m;
        longint v;
        for (int n = 0; n < 24; n++) begin
            raw = {$urandom(), $urandom()};
            r = raw[33:0];
            if (n % 4 == 1) r = r >>> 20;
            v = r;
            m = 1'($urandom_range(0, 1));
            send(v, m, c);
            beats4(v, m, -1, 0, 1'b1, "random");
        end
    endtask

    task automatic test_d8_hold();
        longint e;
        in_valid8 = 1'b1;
        x2_8 = 34'sd1;
        mode8 = 1'b0;
        out_ready8 = 1'b1;
        tick();
        x2_8 = 34'sd2;
        mode8 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            e = model(1, 1'b0, i);
            nvec++;
            if (out_valid8 !== 1'b1 || idx8 !== i[2:0] || longint'(xi2_8) !== e ||
                out_last8 !== (i == 7) || in_ready8 !== 1'b0) begin
                nerr++;
                $display("FAIL d8_sq beat%0d: got valid=%b idx=%0d xi2=%0d last=%b in_ready=%b, want 1 %0d %0d %b 0",
                         i, out_valid8, idx8, xi2_8, out_last8, in_ready8, i, e, (i == 7));
            end
            tick();
        end
        nvec++;
        if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
            nerr++;
            $display("FAIL d8_idle: got in_ready=%b valid=%b, want 1 0", in_ready8, out_valid8);
        end
        tick();
        in_valid8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            e = model(2, 1'b1, i);
            nvec++;
            if (out_valid8 !== 1'b1 || idx8 !== i[2:0] || longint'(xi2_8) !== e || out_last8 !== (i == 7)) begin
                nerr++;
                $display("FAIL d8_lin beat%0d: got valid=%b idx=%0d xi2=%0d last=%b, want 1 %0d %0d %b",
                         i, out_valid8, idx8, xi2_8, out_last8, i, e, (i == 7));
            end
            tick();
        end
        out_ready8 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_squared();
        test_back_to_back();
        test_backpressure();
        test_extremes();
        test_midrun_abort();
        test_random();
        test_d8_hold();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/intpol2_squared_gen.md
Name: intpol2_squared_gen

Overview:
- Parametrised successor of the fixed D=4 squared-term generator in the IntPol2 quadratic interpolator.
- Takes one coefficient sample x2 per interpolation interval and emits D beats x2*i^2 (or x2*i in linear mode), i=0..D-1.
- Uses a first/second-difference recurrence, so there is no multiplier.
- Has its own valid/ready handshakes on input and output, and sits between the coefficient stage and the interpolator output adder.

Parameters:
- DATA_WIDTH, 32, base sample width.
- N_bits, 2, guard bits; input width W = DATA_WIDTH+N_bits.
- LOG2_D, 2, log2 of the interpolation factor; D = 2^LOG2_D; legal range 1..8.
- OUT_W, DATA_WIDTH+N_bits+2*LOG2_D, output width, sized so |x2|*(D-1)^2 never overflows.

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous active-low reset.
- clear  in  1  synchronous clear; same effect as reset; rstn has priority.
- mode  in  1  0 = squared (x2*i^2), 1 = linear (x2*i); sampled on input accept.
- in_valid  in  1  x2 valid.
- in_ready  out  1  block can accept x2.
- x2  in  W signed  coefficient sample.
- out_valid  out  1  xi2 valid.
- out_ready  in  1  downstream accepts xi2.
- xi2  out  OUT_W signed  current term.
- idx  out  LOG2_D  index i of current beat.
- out_last  out  1  high with beat i=D-1.

Behaviour:
- Reset / clear:
  - rstn low or clear high at a clock edge forces state=IDLE, acc=0, delta=0, step=0, cnt=0.
  - Outputs after reset: out_valid=0, out_last=0, xi2=0, idx=0, in_ready=1.
  - This applies mid-run: any beat in flight is abandoned, with no partial completion.
- FSM has two states, IDLE and RUN.
  - in_ready = (state==IDLE); it is registered-state-derived, with no combinational path from out_ready.
  - IDLE, in_valid&&in_ready at edge:
    - latch x2 sign-extended to OUT_W as step.
    - acc<=0, cnt<=0.
    - delta <= x2 (both modes).
    - step2 <= 2*x2 in mode 0, 0 in mode 1.
    - store mode; state<=RUN.
  - RUN: out_valid=1, xi2=acc, idx=cnt, out_last=(cnt==D-1).
  - RUN, out_valid&&out_ready, cnt!=D-1: acc<=acc+delta; delta<=delta+step2; cnt<=cnt+1.
  - RUN, out_valid&&out_ready, cnt==D-1: state<=IDLE, acc<=0, cnt<=0; in_ready high the next cycle.
  - RUN, out_ready low: all registers hold; xi2/idx/out_last stay stable (AXI-style, no drop).
- Latency:
  - First beat (i=0, value 0) is valid 1 cycle after input accept.
  - With out_ready held high, one beat per cycle.
  - Interval = D+1 cycles per input sample.
- Arithmetic:
  - All signed two's complement at OUT_W bits, no saturation; the sizing guarantees no overflow for any x2 in W.
  - Squared recurrence: acc(i+1) = acc(i) + x2*(2i+1).
  - Linear recurrence: acc(i+1) = acc(i) + x2.
- mode and x2 changes while in RUN are ignored until the next accept.
- in_valid during RUN is not accepted; the source must hold it.
- Simultaneous clear with input accept or output handshake: clear wins, and no transfer is counted.
- LOG2_D=1: D=2, so out_last rises on idx=1.

Decomposition:
- Package intpol2_pkg:
  - state enum {IDLE, RUN}.
  - localparam helper for OUT_W.
  - mode encodings MODE_SQ=0, MODE_LIN=1.
- One sub-module, intpol2_diff_acc:
  - holds acc/delta/step2 registers with load, advance and hold controls.
  - The top holds the FSM, the counter and the handshakes.

Test Plan:
- D=4, mode 0, x2=3, out_ready=1 -> xi2 = 0,3,12,27 on consecutive cycles; idx = 0..3; out_last only on 27; in_ready returns 1 the cycle after.
- D=4, mode 1, x2=3 -> 0,3,6,9; then mode 0, x2=-5 back-to-back -> 0,-5,-20,-45, with an interval of 5 cycles per sample.
- Backpressure: mode 0, x2=7, out_ready low for 3 cycles while xi2=28 (i=2) -> 28 held stable with idx=2, then 63 with out_last=1; no skipped or duplicated beat.
- Extremes, LOG2_D=2, W=34:
  - x2 = 2^33-1 -> final beat 9*(2^33-1) exact in 38 bits.
  - x2 = -2^33 -> final beat -9*2^33 exact.
- Mid-run reset/clear: assert clear at i=1 -> next cycle out_valid=0, in_ready=1, xi2=0; a new x2=2 then gives 0,2,8,18. Repeat with rstn low; same result.
- LOG2_D=3, mode 0, x2=1 -> 0,1,4,9,16,25,36,49 with out_last on 49; in_valid held during RUN is not accepted until IDLE.
